seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Iterative multi-cycle shifter for the multi-cycle MIPS datapath.
- Complements the combinational fixed left-by-2 shifter. It provides variable shifts by one bit per clock: right logical, right arithmetic, left logical, and rotate right.
- Driven by the control unit for SLL/SRL/SRA/SLLV/SRLV/SRAV.
- Result feeds the register-file write-data mux.
- Control unit stalls on busy and advances on done.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR (rotate right).
- data_in  input  WIDTH  operand, from register B.
- shamt  input  SHAMT_W  shift amount, from IR[10:6] or register A[4:0].
- result  output  WIDTH  shifted value; valid when done=1 and held until next accepted start.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  single-cycle pulse when result becomes final.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset takes priority over everything, including mid-operation:
  - state <= IDLE
  - result <= 0, count <= 0
  - done = 0, busy = 0
  - an in-flight operation is discarded with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: latch data_in into result, latch shamt into count, latch op, go to SHIFT.
  - If start=0: hold; result keeps its last value.
- SHIFT, when count != 0, per cycle:
  - SLL: result <= result << 1, zero fill.
  - SRL: result <= result >> 1, zero fill.
  - SRA: result <= {result[WIDTH-1], result[WIDTH-1:1]}, sign fill.
  - ROR: result <= {result[0], result[WIDTH-1:1]}.
  - Then count <= count - 1.
- SHIFT, when count == 0: no shift, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency:
  - The start edge is E0. done is high in the cycle following edge E(shamt+1).
  - shamt=0 gives done 1 cycle after E0; shamt=31 gives 32 cycles.
- busy is 0 in IDLE and 1 in SHIFT and DONE.
- start while busy=1 is ignored. Inputs are not re-sampled, and the latched op and shamt govern the whole operation.
- start in the same cycle as done is ignored. A new start is accepted only in the first IDLE cycle or later, so back-to-back ops have a minimum 1 IDLE cycle between them.
- Changes to op, data_in or shamt after acceptance have no effect.
- Boundary cases:
  - shamt=0 returns data_in unchanged for all ops.
  - shamt=31 with SRA gives all sign bits.
  - ROR by WIDTH-1 equals rotate left by 1.
- No wrap of count below 0; the count==0 check precedes any decrement.
- All outputs are registered or decoded from state; no combinational path from inputs to outputs.

Test Plan:
1. Reset mid-op:
   - Stimulus: start SLL, data 0x00000001, shamt 20; assert reset at the 5th SHIFT cycle.
   - Required: next cycle result=0, busy=0, done=0; no done pulse for 40 cycles afterward.
2. SRA sign fill:
   - Stimulus: data 0x80000000, shamt 4, op=10.
   - Required: done after 5 cycles, result=0xF8000000. Repeat with op=01; required result=0x08000000.
3. SLL and zero shift:
   - Stimulus: data 0x0000000A, shamt 2, SLL.
   - Required: result=0x00000028, done 3 cycles after start. Then shamt 0 with any op: result=0x0000000A, done 1 cycle after start.
4. Rotate and maximum shift:
   - Stimulus: ROR data 0x00000001 shamt 1, then SRA data 0x7FFFFFFF shamt 31.
   - Required: first result=0x80000000; second result=0x00000000 with done 32 cycles after start.
5. Handshake:
   - Stimulus: hold start=1 continuously with changing data_in/shamt during an SLL 0x1 shamt 3.
   - Required: result=0x00000008. The next op is accepted only in the cycle after done, and exactly one done pulse occurs per accepted op.
6. Random regression:
   - Stimulus: 1000 random (op, data, shamt) triples.
   - Required: result matches the reference-model shift/rotate; done latency = shamt+1.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Iterative one-bit-per-cycle shifter for the multi-cycle MIPS datapath.
// Supports SLL, SRL, SRA and ROR; the control unit stalls on busy and advances on done.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t             state;
    op_t                op_q;
    logic [SHAMT_W-1:0] count;

    // One-bit step of the latched operation applied to the running result.
    function automatic logic [WIDTH-1:0] step(input op_t o, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        case (o)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset is checked first so it wins even mid-operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_SLL;
            count  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        result <= data_in;
                        count  <= shamt;
                        op_q   <= op_t'(op);
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Zero test precedes the decrement, so count never wraps.
                    if (count == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        result <= step(op_q, result);
                        count  <= count - SHAMT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed corner cases plus random
// operations compared against an arithmetic shift/rotate reference model.
module tb_seq_shift_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Whole-operand reference: shifts by the full amount in one step.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
        logic [63:0] dd;
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} >> s;
                return dd[31:0];
            end
        endcase
    endfunction

    // Presents one request and returns at the falling edge after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input int s);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = SHAMT_W'(s);
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom);
        data_in = $urandom;
        shamt   = SHAMT_W'($urandom);
    endtask

    // lat = number of rising edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = -1;
        res = result;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input int s, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic [31:0] res;
        issue(o, d, s);
        wait_done(lat, res);
        check({tag, "_res"}, 64'(res), 64'(exp_res));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        check({tag, "_hold"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        int          lat;
        int          n_done;
        logic [31:0] res;
        logic [1:0]  o;
        logic [31:0] d;
        int          s;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        data_in = '0;
        shamt   = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 64'(result), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset = 1'b0;

        // Reset during the fifth shifting cycle discards the operation.
        issue(2'b00, 32'h0000_0001, 20);
        repeat (4) @(negedge clk);
        check("mid_busy_pre", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_result", 64'(result), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        reset  = 1'b0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid_no_done", 64'(n_done), 64'(0));
        check("mid_result_held", 64'(result), 64'(0));

        run_op("sra_sign", 2'b10, 32'h8000_0000, 4, 32'hF800_0000, 5);
        run_op("srl_zero", 2'b01, 32'h8000_0000, 4, 32'h0800_0000, 5);
        run_op("sll_2", 2'b00, 32'h0000_000A, 2, 32'h0000_0028, 3);
        for (int i = 0; i < 4; i++)
            run_op("shamt0", 2'(i), 32'h0000_000A, 0, 32'h0000_000A, 1);
        run_op("ror_1", 2'b11, 32'h0000_0001, 1, 32'h8000_0000, 2);
        run_op("sra_31", 2'b10, 32'h7FFF_FFFF, 31, 32'h0000_0000, 32);
        run_op("sra_31_neg", 2'b10, 32'h8000_1234, 31, 32'hFFFF_FFFF, 32);
        run_op("ror_31", 2'b11, 32'h8000_0003, 31, 32'h0000_0007, 32);

        // Handshake: start held high with changing inputs throughout.
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b00;
        data_in = 32'h0000_0001;
        shamt   = 5'd3;
        @(negedge clk);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            op      = 2'($urandom);
            data_in = $urandom;
            shamt   = SHAMT_W'($urandom);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        check("hs_res", 64'(result), 64'(32'h0000_0008));
        check("hs_lat", 64'(lat), 64'(4));
        op      = 2'b01;
        data_in = 32'h0000_0003;
        shamt   = 5'd2;
        @(negedge clk);
        check("hs_idle_busy", 64'(busy), 64'(0));
        check("hs_idle_done", 64'(done), 64'(0));
        check("hs_idle_hold", 64'(result), 64'(32'h0000_0008));
        op      = 2'b00;
        data_in = 32'h0000_0005;
        shamt   = 5'd1;
        @(negedge clk);
        check("hs_accept", 64'(busy), 64'(1));
        check("hs_accept_done", 64'(done), 64'(0));
        start   = 1'b0;
        wait_done(lat, res);
        check("hs2_res", 64'(res), 64'(32'h0000_000A));
        check("hs2_lat", 64'(lat), 64'(2));
        @(negedge clk);
        check("hs2_pulse", 64'(done), 64'(0));

        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(0, 3));
            d = $urandom;
            s = $urandom_range(0, 31);
            run_op("rnd", o, d, s, model(o, d, s), s + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
